// File: rtl/bios_load_sink.sv
// System-side responder for the BIOS download handshake: buffers words and commits them to boot memory.
// Optional running checksum of accepted words is compiled in when BIOS_CHECKSUM_EN is defined.
module bios_load_sink #(
  parameter int            AW         = 13,
  parameter int            DW         = 16,
  parameter int            WORDS      = 8192,
  parameter int            FIFO_DEPTH = 4,
  parameter logic [DW-1:0] EXPECT_SUM = {DW{1'b0}}
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] bios_addr,
  input  logic [DW-1:0] bios_din,
  input  logic          bios_wr,
  output logic          bios_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic          mem_busy,
  output logic          bios_loaded,
  output logic          cpu_reset,
  output logic          load_err,
  output logic [DW-1:0] checksum,
  output logic          checksum_ok
);

  localparam int          PW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] WORDS_C     = (AW+1)'(WORDS);
  localparam logic [PW:0] REQ_MAX_OCC = (PW+1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_DONE, S_ERROR} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_occ;
  logic [AW-1:0] r_exp;
  logic [AW:0]   r_cnt;
  logic          r_req;
  logic          r_err;
  logic          r_we;
  logic [AW-1:0] r_maddr;
  logic [DW-1:0] r_mdin;

  logic w_xfer;
  logic w_push;
  logic w_bad;
  logic w_last;
  logic w_mem_act;
  logic w_wr_done;
  logic w_pop;
  logic w_sum_ok;
  logic w_unused_cfg;

  always_comb begin
    w_xfer    = r_req & bios_wr & (r_state == S_LOAD);
    w_push    = w_xfer & (bios_addr == r_exp);
    w_bad     = w_xfer & (bios_addr != r_exp);
    w_last    = w_push & (r_cnt == WORDS_C - 1'b1);
    w_mem_act = (r_state == S_LOAD) | (r_state == S_DRAIN);
    w_wr_done = r_we & ~mem_busy;
    w_pop     = w_mem_act & (r_occ != '0) & (~r_we | w_wr_done);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_bad)       w_state_nxt = S_ERROR;
        else if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_occ == '0) && !r_we) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // Control and memory-port registers; ready is decided from the current occupancy,
  // so one more word can still land in the cycle that fills the buffer.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state  <= S_LOAD;
      r_req    <= 1'b0;
      r_err    <= 1'b0;
      r_exp    <= '0;
      r_cnt    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      r_we     <= 1'b0;
      r_maddr  <= '0;
      r_mdin   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == S_LOAD) & (r_occ <= REQ_MAX_OCC);
      if (w_bad) r_err <= 1'b1;
      if (w_push) begin
        r_exp    <= r_exp + 1'b1;
        r_cnt    <= r_cnt + 1'b1;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_pop) begin
        r_we   <= 1'b1;
        r_mdin <= r_fifo[r_rd_ptr];
      end else if (w_wr_done) begin
        r_we <= 1'b0;
      end
      if (w_wr_done) r_maddr <= r_maddr + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) r_fifo[r_wr_ptr] <= bios_din;
  end

`ifdef BIOS_CHECKSUM_EN
  logic [DW-1:0] r_sum;

  function automatic logic [DW-1:0] f_wrap_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk_sys) begin
    if (reset)       r_sum <= '0;
    else if (w_push) r_sum <= f_wrap_add(r_sum, bios_din);
  end

  assign checksum    = r_sum;
  assign w_sum_ok    = (r_sum == EXPECT_SUM);
  assign checksum_ok = w_sum_ok & bios_loaded;
`else
  assign checksum    = '0;
  assign w_sum_ok    = 1'b1;
  assign checksum_ok = 1'b1;
`endif

  assign w_unused_cfg = ^EXPECT_SUM;

  assign bios_req    = r_req;
  assign mem_we      = r_we;
  assign mem_addr    = r_maddr;
  assign mem_din     = r_mdin;
  assign bios_loaded = (r_state == S_DONE);
  assign load_err    = r_err;
  assign cpu_reset   = ~bios_loaded | reset | ~w_sum_ok;

endmodule

// File: tb/tb_bios_load_sink.sv
// Bench for bios_load_sink: randomized loader/memory traffic against an image-level reference model.
module tb_bios_load_sink;
  localparam int          AW      = 13;
  localparam int          DW      = 16;
  localparam int          WORDS   = 16;
  localparam int          DEPTH   = 4;
  localparam logic [15:0] EXP_SUM = 16'h0010;
`ifdef BIOS_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] bios_addr = '0;
  logic [DW-1:0] bios_din = '0;
  logic          bios_wr = 1'b0;
  logic          mem_busy = 1'b0;
  logic          bios_req, mem_we, bios_loaded, cpu_reset, load_err, checksum_ok;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, checksum;

  always #5 clk_sys = ~clk_sys;

  bios_load_sink #(.AW(AW), .DW(DW), .WORDS(WORDS), .FIFO_DEPTH(DEPTH), .EXPECT_SUM(EXP_SUM)) dut (
    .clk_sys(clk_sys), .reset(reset), .bios_addr(bios_addr), .bios_din(bios_din),
    .bios_wr(bios_wr), .bios_req(bios_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_busy(mem_busy), .bios_loaded(bios_loaded), .cpu_reset(cpu_reset),
    .load_err(load_err), .checksum(checksum), .checksum_ok(checksum_ok));

  int n_vec = 0, n_err = 0, cyc = 0;
  logic [AW-1:0] a_addr [32];
  logic [DW-1:0] a_dat [32];
  int ld_n = 0, ld_idx = 0, gap_pct = 0, busy_mode = 0;
  logic post_wr = 1'b0;
  logic [AW-1:0] post_addr = '0;
  logic xfer_pend = 1'b0;
  int first_xfer_cyc = -1, first_we_cyc = -1, last_wr_cyc = 0;
  int stall_left = 0, acc_at_stall_end = 0;
  bit stalled = 0, hold_bad = 0, req_dropped = 0;
  logic [AW-1:0] wq_addr [$];
  logic [DW-1:0] wq_dat [$];

  // Record every committed memory write.
  always @(negedge clk_sys) begin
    if (mem_we && first_we_cyc < 0) first_we_cyc = cyc;
    if (mem_we && !mem_busy) begin
      wq_addr.push_back(mem_addr);
      wq_dat.push_back(mem_din);
      last_wr_cyc = cyc;
    end
  end

  function automatic logic [15:0] img_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(a_dat[i]);
    return 16'(s);
  endfunction

  // Advance one clock: loader and memory models react to what happened at the edge.
  task automatic tick();
    @(negedge clk_sys);
    xfer_pend = bios_req && bios_wr && !reset;
    @(posedge clk_sys);
    #1;
    cyc++;
    if (xfer_pend && ld_idx < ld_n) begin
      ld_idx++;
      if (ld_idx == 1) first_xfer_cyc = cyc;
    end
    if (ld_idx < ld_n) begin
      bios_wr = ($urandom_range(0, 99) >= gap_pct);
      bios_addr = bios_wr ? a_addr[ld_idx] : AW'($urandom);
      bios_din = bios_wr ? a_dat[ld_idx] : DW'($urandom);
    end else begin
      bios_wr = post_wr;
      bios_addr = post_addr;
      bios_din = DW'($urandom);
    end
    case (busy_mode)
      1: mem_busy = ($urandom_range(0, 2) == 0);
      2: begin
        if (stall_left > 0) begin
          stall_left--;
          mem_busy = 1'b1;
          if (mem_we !== 1'b1 || mem_addr !== 13'd2 || mem_din !== 16'h1002) hold_bad = 1;
          if (!bios_req) req_dropped = 1;
          if (stall_left == 0) acc_at_stall_end = ld_idx;
        end else if (!stalled && mem_we && mem_addr == 13'd2) begin
          stalled = 1;
          stall_left = 9;
          mem_busy = 1'b1;
        end else begin
          mem_busy = 1'b0;
        end
      end
      default: mem_busy = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1; ld_n = 0; ld_idx = 0; post_wr = 1'b0; busy_mode = 0; gap_pct = 0;
    tick();
    tick();
    reset = 1'b0;
    wq_addr.delete(); wq_dat.delete();
    first_we_cyc = -1; first_xfer_cyc = -1;
    stalled = 0; stall_left = 0; hold_bad = 0; req_dropped = 0; acc_at_stall_end = 0;
  endtask

  task automatic start_load(input int n, input int gap);
    ld_n = n; ld_idx = 0; gap_pct = gap;
    bios_wr = 1'b1; bios_addr = a_addr[0]; bios_din = a_dat[0];
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick();
      if (bios_loaded || load_err) ok = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if ({bios_req, mem_we, bios_loaded, cpu_reset, load_err} !== 5'b00010) begin n_err++; $display("FAIL reset_ctrl: got %b want 00010", {bios_req, mem_we, bios_loaded, cpu_reset, load_err}); end
    n_vec++; if (mem_addr !== '0 || mem_din !== '0) begin n_err++; $display("FAIL reset_mem: got %0h/%0h want 0/0", mem_addr, mem_din); end
    n_vec++; if (checksum !== '0) begin n_err++; $display("FAIL reset_sum: got %0h want 0", checksum); end
    n_vec++; if (checksum_ok !== !CS_EN) begin n_err++; $display("FAIL reset_sum_ok: got %0b want %0b", checksum_ok, !CS_EN); end
  endtask

  task automatic test_clean_load();
    bit ok;
    logic [15:0] s;
    do_reset();
    for (int i = 0; i < WORDS; i++) begin a_addr[i] = AW'(i); a_dat[i] = 16'h1000 + 16'(i); end
    s = img_sum(WORDS);
    start_load(WORDS, 0);
    wait_end(300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL clean_timeout: got 0 want 1"); end
    n_vec++; if (wq_addr.size() != WORDS) begin n_err++; $display("FAIL clean_nwr: got %0d want %0d", wq_addr.size(), WORDS); end
    for (int k = 0; k < WORDS && k < wq_addr.size(); k++) begin
      n_vec++; if (wq_addr[k] !== AW'(k) || wq_dat[k] !== a_dat[k]) begin n_err++; $display("FAIL clean_wr%0d: got %0h/%0h want %0h/%0h", k, wq_addr[k], wq_dat[k], k, a_dat[k]); end
    end
    n_vec++; if (first_we_cyc - (first_xfer_cyc - 1) !== 2) begin n_err++; $display("FAIL clean_latency: got %0d want 2", first_we_cyc - (first_xfer_cyc - 1)); end
    n_vec++; if (cyc - last_wr_cyc > 3 || cyc <= last_wr_cyc) begin n_err++; $display("FAIL clean_done_lat: got %0d want 1..3", cyc - last_wr_cyc); end
    n_vec++; if ({bios_loaded, load_err, bios_req} !== 3'b100) begin n_err++; $display("FAIL clean_state: got %b want 100", {bios_loaded, load_err, bios_req}); end
    n_vec++; if (cpu_reset !== (CS_EN && s != EXP_SUM)) begin n_err++; $display("FAIL clean_cpu_reset: got %0b want %0b", cpu_reset, CS_EN && s != EXP_SUM); end
    n_vec++; if (checksum !== (CS_EN ? s : 16'h0)) begin n_err++; $display("FAIL clean_sum: got %0h want %0h", checksum, CS_EN ? s : 16'h0); end
  endtask

  task automatic test_post_done();
    int n0 = wq_addr.size();
    post_wr = 1'b1; post_addr = '0;
    repeat (6) tick();
    n_vec++; if (wq_addr.size() != n0 || mem_we !== 1'b0) begin n_err++; $display("FAIL post_writes: got %0d want %0d", wq_addr.size(), n0); end
    n_vec++; if (load_err !== 1'b0 || bios_loaded !== 1'b1) begin n_err++; $display("FAIL post_state: got err=%0b loaded=%0b want 0/1", load_err, bios_loaded); end
    post_wr = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    for (int i = 0; i < WORDS; i++) begin a_addr[i] = AW'(i); a_dat[i] = 16'h1000 + 16'(i); end
    busy_mode = 2;
    start_load(WORDS, 0);
    wait_end(400, ok);
    n_vec++; if (!ok || !stalled) begin n_err++; $display("FAIL bp_run: got ok=%0b stalled=%0b want 1/1", ok, stalled); end
    n_vec++; if (hold_bad) begin n_err++; $display("FAIL bp_hold: got changed want held 2/1002"); end
    n_vec++; if (!req_dropped) begin n_err++; $display("FAIL bp_req_drop: got 0 want 1"); end
    n_vec++; if (acc_at_stall_end != 3 + DEPTH) begin n_err++; $display("FAIL bp_accepted: got %0d want %0d", acc_at_stall_end, 3 + DEPTH); end
    n_vec++; if (wq_addr.size() != WORDS) begin n_err++; $display("FAIL bp_nwr: got %0d want %0d", wq_addr.size(), WORDS); end
    for (int k = 0; k < WORDS && k < wq_addr.size(); k++) begin
      n_vec++; if (wq_addr[k] !== AW'(k) || wq_dat[k] !== a_dat[k]) begin n_err++; $display("FAIL bp_wr%0d: got %0h/%0h want %0h/%0h", k, wq_addr[k], wq_dat[k], k, a_dat[k]); end
    end
    n_vec++; if (bios_loaded !== 1'b1) begin n_err++; $display("FAIL bp_loaded: got %0b want 1", bios_loaded); end
  endtask

  task automatic test_addr_skip();
    do_reset();
    a_addr[0] = 13'd0; a_addr[1] = 13'd1; a_addr[2] = 13'd3;
    for (int i = 0; i < 3; i++) a_dat[i] = 16'h2000 + 16'(i);
    start_load(3, 0);
    for (int k = 0; k < 50 && ld_idx < 3; k++) tick();
    n_vec++; if (ld_idx != 3 || load_err !== 1'b1) begin n_err++; $display("FAIL skip_err: got idx=%0d err=%0b want 3/1", ld_idx, load_err); end
    repeat (10) tick();
    n_vec++; if (wq_addr.size() != 2) begin n_err++; $display("FAIL skip_nwr: got %0d want 2", wq_addr.size()); end
    for (int k = 0; k < 2 && k < wq_addr.size(); k++) begin
      n_vec++; if (wq_addr[k] !== AW'(k) || wq_dat[k] !== a_dat[k]) begin n_err++; $display("FAIL skip_wr%0d: got %0h/%0h want %0h/%0h", k, wq_addr[k], wq_dat[k], k, a_dat[k]); end
    end
    n_vec++; if ({bios_req, bios_loaded, cpu_reset, load_err} !== 4'b0011) begin n_err++; $display("FAIL skip_state: got %b want 0011", {bios_req, bios_loaded, cpu_reset, load_err}); end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    do_reset();
    for (int i = 0; i < WORDS; i++) begin a_addr[i] = AW'(i); a_dat[i] = 16'h3000 + 16'(i); end
    start_load(WORDS, 0);
    for (int k = 0; k < 100 && ld_idx < 7; k++) tick();
    do_reset();
    n_vec++; if (mem_addr !== '0 || load_err !== 1'b0 || bios_req !== 1'b0) begin n_err++; $display("FAIL mid_reset: got addr=%0h err=%0b req=%0b want 0/0/0", mem_addr, load_err, bios_req); end
    start_load(WORDS, 0);
    wait_end(300, ok);
    n_vec++; if (!ok || bios_loaded !== 1'b1 || load_err !== 1'b0) begin n_err++; $display("FAIL mid_done: got loaded=%0b err=%0b want 1/0", bios_loaded, load_err); end
    n_vec++; if (wq_addr.size() != WORDS) begin n_err++; $display("FAIL mid_nwr: got %0d want %0d", wq_addr.size(), WORDS); end
    for (int k = 0; k < WORDS && k < wq_addr.size(); k++) begin
      n_vec++; if (wq_addr[k] !== AW'(k) || wq_dat[k] !== a_dat[k]) begin n_err++; $display("FAIL mid_wr%0d: got %0h/%0h want %0h/%0h", k, wq_addr[k], wq_dat[k], k, a_dat[k]); end
    end
  endtask

  task automatic test_checksum();
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < WORDS; i++) begin a_addr[i] = AW'(i); a_dat[i] = 16'h0001; end
      if (pass == 1) a_dat[5] = 16'h0002;
      start_load(WORDS, 0);
      wait_end(300, ok);
      n_vec++; if (!ok || bios_loaded !== 1'b1) begin n_err++; $display("FAIL cs%0d_loaded: got %0b want 1", pass, bios_loaded); end
      n_vec++; if (checksum !== (CS_EN ? img_sum(WORDS) : 16'h0)) begin n_err++; $display("FAIL cs%0d_sum: got %0h want %0h", pass, checksum, CS_EN ? img_sum(WORDS) : 16'h0); end
      n_vec++; if (checksum_ok !== (!CS_EN || img_sum(WORDS) == EXP_SUM)) begin n_err++; $display("FAIL cs%0d_ok: got %0b want %0b", pass, checksum_ok, !CS_EN || img_sum(WORDS) == EXP_SUM); end
      n_vec++; if (cpu_reset !== (CS_EN && img_sum(WORDS) != EXP_SUM)) begin n_err++; $display("FAIL cs%0d_cpu_reset: got %0b want %0b", pass, cpu_reset, CS_EN && img_sum(WORDS) != EXP_SUM); end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [15:0] s;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int i = 0; i < WORDS; i++) begin a_addr[i] = AW'(i); a_dat[i] = DW'($urandom); end
      s = img_sum(WORDS);
      busy_mode = 1;
      start_load(WORDS, 30);
      wait_end(2000, ok);
      n_vec++; if (!ok || bios_loaded !== 1'b1 || load_err !== 1'b0) begin n_err++; $display("FAIL rnd%0d_done: got loaded=%0b err=%0b want 1/0", it, bios_loaded, load_err); end
      n_vec++; if (wq_addr.size() != WORDS) begin n_err++; $display("FAIL rnd%0d_nwr: got %0d want %0d", it, wq_addr.size(), WORDS); end
      for (int k = 0; k < WORDS && k < wq_addr.size(); k++) begin
        n_vec++; if (wq_addr[k] !== AW'(k) || wq_dat[k] !== a_dat[k]) begin n_err++; $display("FAIL rnd%0d_wr%0d: got %0h/%0h want %0h/%0h", it, k, wq_addr[k], wq_dat[k], k, a_dat[k]); end
      end
      n_vec++; if (checksum !== (CS_EN ? s : 16'h0) || cpu_reset !== (CS_EN && s != EXP_SUM)) begin n_err++; $display("FAIL rnd%0d_sum: got %0h/%0b want %0h/%0b", it, checksum, cpu_reset, CS_EN ? s : 16'h0, CS_EN && s != EXP_SUM); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_load();
    test_post_done();
    test_backpressure();
    test_addr_skip();
    test_reset_mid_load();
    test_checksum();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
